// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage in front of the register-file write port.
//
// Two one-entry buffers (ALU results, LSU load data) accept results through
// valid/ready handshakes. Load data is aligned and sign/zero-extended as it is
// captured. A combinational arbiter picks one full buffer per cycle and drives
// the register-file write port. A starvation counter guarantees the ALU entry
// wins after MAX_WAIT consecutive lost arbitrations.
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   flush                      synchronous clear of both buffers
//   alu_valid/alu_ready        ALU handshake; alu_rd, alu_result payload
//   lsu_valid/lsu_ready        LSU handshake; lsu_rd, lsu_data payload,
//                              lsu_funct3 load type, lsu_byte_offset addr[1:0]
//   write_enable/addr/data     register-file write port (combinational)
module writeback_stage #(
    parameter int XLEN      = 32,
    parameter int ADDR_SIZE = 5,
    parameter int MAX_WAIT  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [ADDR_SIZE-1:0] alu_rd,
    input  logic [XLEN-1:0]      alu_result,
    input  logic                 lsu_valid,
    output logic                 lsu_ready,
    input  logic [ADDR_SIZE-1:0] lsu_rd,
    input  logic [XLEN-1:0]      lsu_data,
    input  logic [2:0]           lsu_funct3,
    input  logic [1:0]           lsu_byte_offset,
    output logic                 write_enable,
    output logic [ADDR_SIZE-1:0] write_addr,
    output logic [XLEN-1:0]      write_data
);

    localparam logic [2:0] WAIT_LIMIT = 3'(MAX_WAIT);

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    logic                 alu_full, lsu_full;
    logic [ADDR_SIZE-1:0] alu_rd_q, lsu_rd_q;
    logic [XLEN-1:0]      alu_data_q, lsu_data_q;
    logic [2:0]           wait_cnt;

    logic grant_alu, grant_lsu;
    logic alu_take, lsu_take;

    // Selects the addressed byte/halfword and extends it; LW and the unused
    // encodings pass the word through untouched.
    function automatic logic [XLEN-1:0] extend_load(
        input logic [XLEN-1:0] word,
        input logic [2:0]      funct3,
        input logic [1:0]      offset
    );
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        logic [XLEN-1:0] result;
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
            default: result = word;
        endcase
        return result;
    endfunction

    // LSU wins contention unless the ALU entry has already lost MAX_WAIT times.
    assign grant_alu = alu_full && (!lsu_full || (wait_cnt == WAIT_LIMIT));
    assign grant_lsu = lsu_full && !grant_alu;

    // A granted entry drains this cycle, so it can refill at the same edge.
    assign alu_ready = !flush && (!alu_full || grant_alu);
    assign lsu_ready = !flush && (!lsu_full || grant_lsu);

    assign alu_take = alu_valid && alu_ready;
    assign lsu_take = lsu_valid && lsu_ready;

    // NOTE: every output is given a default first so the case split below
    // cannot leave a path unassigned and infer a latch.
    always_comb begin
        write_enable = 1'b0;
        write_addr   = '0;
        write_data   = '0;
        if (grant_alu) begin
            write_enable = (alu_rd_q != '0);
            write_addr   = alu_rd_q;
            write_data   = alu_data_q;
        end else if (grant_lsu) begin
            write_enable = (lsu_rd_q != '0);
            write_addr   = lsu_rd_q;
            write_data   = lsu_data_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_full <= 1'b0;
            lsu_full <= 1'b0;
            wait_cnt <= '0;
        end else if (flush) begin
            alu_full <= 1'b0;
            lsu_full <= 1'b0;
            wait_cnt <= '0;
        end else begin
            if (alu_take)       alu_full <= 1'b1;
            else if (grant_alu) alu_full <= 1'b0;

            if (lsu_take)       lsu_full <= 1'b1;
            else if (grant_lsu) lsu_full <= 1'b0;

            if (!alu_full || grant_alu)     wait_cnt <= '0;
            else if (wait_cnt != WAIT_LIMIT) wait_cnt <= wait_cnt + 3'd1;
        end
    end

    // NOTE: payload registers carry no reset; they are only observed while
    // the matching full flag is set, and that flag is reset.
    always_ff @(posedge clk) begin
        if (alu_take) begin
            alu_rd_q   <= alu_rd;
            alu_data_q <= alu_result;
        end
        if (lsu_take) begin
            lsu_rd_q   <= lsu_rd;
            lsu_data_q <= extend_load(lsu_data, lsu_funct3, lsu_byte_offset);
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Testbench for writeback_stage: directed vectors, expected register writes
// queued by the stimulus and checked by an independent monitor.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_result = '0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_rd = '0;
    logic [31:0] lsu_data = '0;
    logic [2:0]  lsu_funct3 = '0;
    logic [1:0]  lsu_byte_offset = '0;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    writeback_stage #(.XLEN(32), .ADDR_SIZE(5), .MAX_WAIT(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .alu_valid       (alu_valid),
        .alu_ready       (alu_ready),
        .alu_rd          (alu_rd),
        .alu_result      (alu_result),
        .lsu_valid       (lsu_valid),
        .lsu_ready       (lsu_ready),
        .lsu_rd          (lsu_rd),
        .lsu_data        (lsu_data),
        .lsu_funct3      (lsu_funct3),
        .lsu_byte_offset (lsu_byte_offset),
        .write_enable    (write_enable),
        .write_addr      (write_addr),
        .write_data      (write_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic expect_write(input logic [4:0] addr, input logic [31:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: the write port is purely a function of registered state, so
    // sampling on the falling edge sees the value committed at the next rise.
    always @(negedge clk) begin
        wr_t e;
        if (write_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write",
                         write_addr, write_data);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(write_addr), 32'(e.addr));
                check("write_data", write_data, e.data);
            end
        end
    end

    // Inputs change only on falling edges; each send holds valid until the
    // rising edge where ready was seen high, then drops it on the next fall.
    task automatic alu_send(input logic [4:0] rd, input logic [31:0] d);
        bit done = 1'b0;
        alu_valid  = 1'b1;
        alu_rd     = rd;
        alu_result = d;
        for (int n = 0; n < 20 && !done; n++) begin
            #1;
            if (alu_ready) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        check("alu_accepted", 32'(done), 32'd1);
        @(negedge clk);
        alu_valid = 1'b0;
    endtask

    task automatic lsu_send(input logic [4:0] rd, input logic [31:0] d,
                            input logic [2:0] f3, input logic [1:0] off);
        bit done = 1'b0;
        lsu_valid       = 1'b1;
        lsu_rd          = rd;
        lsu_data        = d;
        lsu_funct3      = f3;
        lsu_byte_offset = off;
        for (int n = 0; n < 20 && !done; n++) begin
            #1;
            if (lsu_ready) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        check("lsu_accepted", 32'(done), 32'd1);
        @(negedge clk);
        lsu_valid = 1'b0;
    endtask

    initial begin
        int low_cnt;

        // Reset state
        #3;
        check("reset_we",        32'(write_enable), 32'd0);
        check("reset_addr",      32'(write_addr),   32'd0);
        check("reset_data",      write_data,        32'd0);
        check("reset_alu_ready", 32'(alu_ready),    32'd1);
        check("reset_lsu_ready", 32'(lsu_ready),    32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single uncontended ALU result, then idle outputs
        expect_write(5'd5, 32'h0000_1234);
        alu_send(5'd5, 32'h0000_1234);
        @(negedge clk);
        #1;
        check("idle_we",   32'(write_enable), 32'd0);
        check("idle_addr", 32'(write_addr),   32'd0);
        check("idle_data", write_data,        32'd0);
        check("t1_drained", 32'(exp_q.size()), 32'd0);

        // Load alignment / extension
        expect_write(5'd1, 32'hFFFF_FFF0);
        expect_write(5'd2, 32'h0000_0080);
        expect_write(5'd3, 32'hFFFF_8070);
        expect_write(5'd4, 32'h0000_F0FF);
        expect_write(5'd6, 32'h8070_F0FF);
        expect_write(5'd10, 32'h8070_F0FF);
        lsu_send(5'd1,  32'h8070_F0FF, 3'd0, 2'd1);
        lsu_send(5'd2,  32'h8070_F0FF, 3'd4, 2'd3);
        lsu_send(5'd3,  32'h8070_F0FF, 3'd1, 2'd2);
        lsu_send(5'd4,  32'h8070_F0FF, 3'd5, 2'd0);
        lsu_send(5'd6,  32'h8070_F0FF, 3'd2, 2'd2);
        lsu_send(5'd10, 32'h8070_F0FF, 3'd3, 2'd1);
        repeat (2) @(negedge clk);
        check("loads_drained", 32'(exp_q.size()), 32'd0);

        // Contention: LSU wins twice, then the starved ALU entry goes through
        expect_write(5'd7, 32'h0000_0007);
        expect_write(5'd8, 32'h0000_0008);
        expect_write(5'd3, 32'h0000_0333);
        expect_write(5'd9, 32'h0000_0009);
        low_cnt = 0;
        fork
            alu_send(5'd3, 32'h0000_0333);
            begin
                lsu_send(5'd7, 32'h0000_0007, 3'd2, 2'd0);
                lsu_send(5'd8, 32'h0000_0008, 3'd2, 2'd0);
                lsu_send(5'd9, 32'h0000_0009, 3'd2, 2'd0);
            end
            begin
                @(posedge clk);
                repeat (6) begin
                    @(negedge clk);
                    #1;
                    if (!alu_ready) low_cnt++;
                end
            end
        join
        check("alu_ready_low_cycles", 32'(low_cnt), 32'd2);
        check("contention_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk);

        // rd == 0: slot consumed, no write
        alu_send(5'd0, 32'hDEAD_BEEF);
        #1;
        check("rd0_alu_ready", 32'(alu_ready), 32'd1);
        @(negedge clk);
        #1;
        check("rd0_alu_ready_after", 32'(alu_ready), 32'd1);
        @(negedge clk);

        // Flush with both full: granted LSU entry written, ALU entry dropped,
        // transfer offered during flush is blocked
        expect_write(5'd21, 32'hCAFE_0001);
        alu_valid = 1'b1; alu_rd = 5'd20; alu_result = 32'h5555_5555;
        lsu_valid = 1'b1; lsu_rd = 5'd21; lsu_data = 32'hCAFE_0001;
        lsu_funct3 = 3'd2; lsu_byte_offset = 2'd0;
        @(posedge clk);
        @(negedge clk);
        alu_valid = 1'b0;
        flush = 1'b1;
        lsu_rd = 5'd22; lsu_data = 32'h7777_7777;
        #1;
        check("flush_alu_ready", 32'(alu_ready), 32'd0);
        check("flush_lsu_ready", 32'(lsu_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        lsu_valid = 1'b0;
        #1;
        check("post_flush_alu_ready", 32'(alu_ready), 32'd1);
        check("post_flush_lsu_ready", 32'(lsu_ready), 32'd1);
        repeat (4) @(negedge clk);
        check("flush_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset between edges while both buffers are full
        alu_valid = 1'b1; alu_rd = 5'd25; alu_result = 32'h2525_2525;
        lsu_valid = 1'b1; lsu_rd = 5'd26; lsu_data = 32'h2626_2626;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_we",        32'(write_enable), 32'd0);
        check("async_rst_addr",      32'(write_addr),   32'd0);
        check("async_rst_data",      write_data,        32'd0);
        check("async_rst_alu_ready", 32'(alu_ready),    32'd1);
        check("async_rst_lsu_ready", 32'(lsu_ready),    32'd1);
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
